// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, branches, J/JAL and JR/JALR redirects.
// Define BRANCH_DELAY_SLOT_EN to execute one delay-slot instruction before a redirect lands.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        Clk_in,
  input  logic        Reset_n_in,
  input  logic        Stall_in,
  input  logic        Branch_in,
  input  logic        Jump_in,
  input  logic        JumpReg_in,
  input  logic [31:0] AluResult_in,
  input  logic [15:0] Imm_in,
  input  logic [25:0] JumpIndex_in,
  output logic [31:0] PC_out,
  output logic [31:0] LinkAddr_out,
  output logic        RedirectPending_out,
  output logic        Misalign_out
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] redirect_tgt;
  logic        redirect;

  assign pc4          = pc_q + 32'd4;
  assign branch_tgt   = pc4 + {{14{Imm_in[15]}}, Imm_in, 2'b00};
  assign jump_tgt     = JumpReg_in ? {AluResult_in[31:2], 2'b00}
                                   : {pc4[31:28], JumpIndex_in, 2'b00};
  assign redirect     = Branch_in | Jump_in;
  // Jump outranks a simultaneous taken branch.
  assign redirect_tgt = Jump_in ? jump_tgt : branch_tgt;

  // A misaligned register target is flagged but still taken with its low bits cleared.
  assign Misalign_out = Jump_in & JumpReg_in & (|AluResult_in[1:0]);
  assign PC_out       = pc_q;

`ifdef BRANCH_DELAY_SLOT_EN
  typedef enum logic {
    SEQ   = 1'b0,
    DELAY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] tgt_q, tgt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    tgt_d   = tgt_q;
    if (!Stall_in) begin
      case (state_q)
        SEQ: begin
          pc_d = pc4;
          if (redirect) begin
            tgt_d   = redirect_tgt;
            state_d = DELAY;
          end
        end
        // Branch/jump flags from the delay-slot instruction are deliberately ignored.
        DELAY: begin
          pc_d    = tgt_q;
          state_d = SEQ;
        end
        default: state_d = SEQ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge Clk_in or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      pc_q    <= RESET_PC;
      state_q <= SEQ;
      tgt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  assign LinkAddr_out        = pc_q + 32'd8;
  assign RedirectPending_out = (state_q == DELAY);
`else
  always_comb begin
    pc_d = pc_q;
    if (!Stall_in) begin
      pc_d = redirect ? redirect_tgt : pc4;
    end
  end

  always_ff @(posedge Clk_in or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign LinkAddr_out        = pc4;
  assign RedirectPending_out = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed cases with literal expectations plus a randomized
// run compared every cycle against an architectural model (both RESET_PC values).
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall, branch, jump, jump_reg;
  logic [31:0] alu;
  logic [15:0] imm;
  logic [25:0] jidx;

  logic [31:0] pc_a, link_a, pc_b, link_b;
  logic        rp_a, mis_a, rp_b, mis_b;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  pc_sequencer u_dut_a (
    .Clk_in(clk), .Reset_n_in(rst_n), .Stall_in(stall), .Branch_in(branch),
    .Jump_in(jump), .JumpReg_in(jump_reg), .AluResult_in(alu), .Imm_in(imm),
    .JumpIndex_in(jidx), .PC_out(pc_a), .LinkAddr_out(link_a),
    .RedirectPending_out(rp_a), .Misalign_out(mis_a)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFF8)) u_dut_b (
    .Clk_in(clk), .Reset_n_in(rst_n), .Stall_in(stall), .Branch_in(branch),
    .Jump_in(jump), .JumpReg_in(jump_reg), .AluResult_in(alu), .Imm_in(imm),
    .JumpIndex_in(jidx), .PC_out(pc_b), .LinkAddr_out(link_b),
    .RedirectPending_out(rp_b), .Misalign_out(mis_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- architectural model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pending;
  } mstate_t;

  mstate_t m_a, m_b;

  function automatic mstate_t model_next(input mstate_t s);
    mstate_t     n;
    logic [31:0] pc4;
    logic [31:0] t;
    n   = s;
    pc4 = s.pc + 32'd4;
    if (s.pending) begin
      n.pc      = s.tgt;
      n.pending = 1'b0;
    end else if (!(branch || jump)) begin
      n.pc = pc4;
    end else begin
      if (jump && jump_reg)  t = alu & ~32'd3;
      else if (jump)         t = {pc4[31:28], 28'(jidx) * 28'd4};
      else                   t = pc4 + 32'($signed(imm)) * 32'd4;
`ifdef BRANCH_DELAY_SLOT_EN
      n.pc      = pc4;
      n.tgt     = t;
      n.pending = 1'b1;
`else
      n.pc      = t;
`endif
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '{pc: 32'h0040_0000, tgt: 32'h0, pending: 1'b0};
      m_b <= '{pc: 32'hFFFF_FFF8, tgt: 32'h0, pending: 1'b0};
    end else if (!stall) begin
      m_a <= model_next(m_a);
      m_b <= model_next(m_b);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic mis_exp;
    if (chk_en) begin
      mis_exp = jump && jump_reg && (alu % 4 != 0);
      check("pc_a", pc_a, m_a.pc);
      check("pc_b", pc_b, m_b.pc);
      check("mis_a", 32'(mis_a), 32'(mis_exp));
      check("mis_b", 32'(mis_b), 32'(mis_exp));
`ifdef BRANCH_DELAY_SLOT_EN
      check("rp_a", 32'(rp_a), 32'(m_a.pending));
      check("rp_b", 32'(rp_b), 32'(m_b.pending));
      check("link_a", link_a, m_a.pc + 32'd8);
      check("link_b", link_b, m_b.pc + 32'd8);
`else
      check("rp_a", 32'(rp_a), 32'd0);
      check("rp_b", 32'(rp_b), 32'd0);
      check("link_a", link_a, m_a.pc + 32'd4);
      check("link_b", link_b, m_b.pc + 32'd4);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; branch = 0; jump = 0; jump_reg = 0;
    alu = '0; imm = '0; jidx = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();
    check("reset_pc_a", pc_a, 32'h0040_0000);
    check("reset_pc_b", pc_b, 32'hFFFF_FFF8);
    check("reset_rp_a", 32'(rp_a), 32'd0);
    chk_en = 1;
    rst_n  = 1'b1;

    // Sequential fetch, including wrap on the high-reset instance
    tick();
    check("seq1_a", pc_a, 32'h0040_0004);
    check("seq1_b", pc_b, 32'hFFFF_FFFC);
    tick();
    check("seq2_a", pc_a, 32'h0040_0008);
    check("seq2_b", pc_b, 32'h0000_0000);
    tick();
    check("seq3_a", pc_a, 32'h0040_000C);
    tick();
    check("seq4_a", pc_a, 32'h0040_0010);

    // Backward branch, offset -4 words
    branch = 1; imm = 16'hFFFC;
    tick();
    branch = 0; imm = '0;
`ifdef BRANCH_DELAY_SLOT_EN
    check("br_slot_pc", pc_a, 32'h0040_0014);
    check("br_slot_rp", 32'(rp_a), 32'd1);
    tick();
`endif
    check("br_tgt_pc", pc_a, 32'h0040_0004);
    check("br_tgt_rp", 32'(rp_a), 32'd0);

    // Stall (in DELAY when slots are enabled) ignores redirects, then reset mid-cycle
    branch = 1; imm = 16'h0000;
    tick();
    branch = 0;
    stall = 1; jump = 1; jidx = 26'h3FF_FFFF;
    tick();
    tick();
    check("stall_hold_pc", pc_a, 32'h0040_0008);
`ifdef BRANCH_DELAY_SLOT_EN
    check("stall_hold_rp", 32'(rp_a), 32'd1);
`endif
    rst_n = 1'b0;
    #2;
    check("async_rst_pc", pc_a, 32'h0040_0000);
    check("async_rst_rp", 32'(rp_a), 32'd0);
    rst_n = 1'b1;
    idle_inputs();
    tick();
    check("post_rst_pc", pc_a, 32'h0040_0004);

    // Misaligned register jump from 0x00400020
    for (int i = 0; i < 20 && pc_a !== 32'h0040_0020; i++) tick();
    check("reach_400020", pc_a, 32'h0040_0020);
    jump = 1; jump_reg = 1; alu = 32'h0040_1003;
    #1;
    check("misalign", 32'(mis_a), 32'd1);
`ifdef BRANCH_DELAY_SLOT_EN
    check("link_jalr", link_a, 32'h0040_0028);
`else
    check("link_jalr", link_a, 32'h0040_0024);
`endif
    tick();
    idle_inputs();
`ifdef BRANCH_DELAY_SLOT_EN
    check("jr_slot_pc", pc_a, 32'h0040_0024);
    tick();
`endif
    check("jr_tgt_pc", pc_a, 32'h0040_1000);

    // High reset vector: wrap, then jump beats branch
    rst_n = 1'b0;
    #2;
    check("wrap_rst_pc", pc_b, 32'hFFFF_FFF8);
    rst_n = 1'b1;
    tick();
    check("wrap1_pc", pc_b, 32'hFFFF_FFFC);
    tick();
    check("wrap2_pc", pc_b, 32'h0000_0000);
    branch = 1; jump = 1; jump_reg = 0; jidx = 26'h1; imm = 16'h0100;
    tick();
    idle_inputs();
`ifdef BRANCH_DELAY_SLOT_EN
    check("jwin_slot_pc", pc_b, 32'h0000_0004);
    check("jwin_slot_rp", 32'(rp_b), 32'd1);
    tick();
`endif
    check("jwin_tgt_pc", pc_b, 32'h0000_0004);

    // Randomized run with occasional mid-cycle resets
    for (int c = 0; c < 3000; c++) begin
      stall    = ($urandom_range(0, 3) == 0);
      branch   = ($urandom_range(0, 4) == 0);
      jump     = ($urandom_range(0, 6) == 0);
      jump_reg = $urandom_range(0, 1) == 1;
      alu      = $urandom;
      imm      = 16'($urandom);
      jidx     = 26'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000: PC value loaded on reset.
REQ-002 Clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 Reset_n_in  input  1  asynchronous, active-low reset.
REQ-004 Stall_in  input  1  1 = hold PC, state and target register this cycle.
REQ-005 Branch_in  input  1  taken-branch flag from ALU Branch_out.
REQ-006 Jump_in  input  1  jump flag from ALU Jump_out.
REQ-007 JumpReg_in  input  1  1 = register jump (JR/JALR), 0 = J/JAL index jump; valid only with Jump_in.
REQ-008 AluResult_in  input  32  ALU O_out; register-jump target.
REQ-009 Imm_in  input  16  branch offset field of current instruction.
REQ-010 JumpIndex_in  input  26  jump index field of current instruction.
REQ-011 PC_out  output  32  address of current instruction, registered.
REQ-012 LinkAddr_out  output  32  JAL/JALR link value, combinational.
REQ-013 RedirectPending_out  output  1  1 while in DELAY state.
REQ-014 Misalign_out  output  1  combinational; 1 when Jump_in & JumpReg_in & AluResult_in[1:0] != 0.

Function
REQ-015 PC4 = PC_out + 4, modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-016 Branch target = PC4 + (sign-extended Imm_in << 2), modulo 2^32.
REQ-017 Jump target = {PC4[31:28], JumpIndex_in, 2'b00} when JumpReg_in = 0; {AluResult_in[31:2], 2'b00} when JumpReg_in = 1.
REQ-018 Jump_in has priority over Branch_in when both are 1.
REQ-019 States: SEQ and DELAY; target register TGT is 32 bits.
REQ-020 Stall_in = 1: PC_out, state and TGT are unchanged, regardless of other inputs.
REQ-021 SEQ, no Branch_in/Jump_in: PC_out <= PC4; state stays SEQ.
REQ-022 SEQ, Branch_in or Jump_in: behaviour is set by REQ-030/REQ-031.
REQ-023 DELAY, not stalled: PC_out <= TGT; state <= SEQ.
REQ-024 DELAY: Branch_in and Jump_in are ignored, so a branch in a delay slot is not taken.
REQ-025 Misalign_out does not block the jump; the low two target bits are always forced to 0.
REQ-026 Outputs depend only on registered state and current inputs; there is no combinational path from Stall_in to PC_out.

Reset
REQ-027 Reset_n_in = 0 asynchronously sets PC_out = RESET_PC, state = SEQ, TGT = 0, and RedirectPending_out = 0.
REQ-028 Reset asserted while in DELAY discards the pending target; the first fetch after release is RESET_PC.
REQ-029 Reset release is sampled synchronously; the first PC advance occurs on the first rising edge with Reset_n_in = 1.

Configuration
REQ-030 With macro BRANCH_DELAY_SLOT_EN defined: a SEQ-state redirect loads PC_out <= PC4 and TGT <= target, enters DELAY, and LinkAddr_out = PC_out + 8.
REQ-031 Without BRANCH_DELAY_SLOT_EN: a SEQ-state redirect loads PC_out <= target directly, DELAY is never entered, RedirectPending_out is tied 0, and LinkAddr_out = PC4.

Verification
REQ-032 Reset, then 3 unstalled cycles -> PC_out = 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
REQ-033 At PC 0x00400010, Branch_in = 1 and Imm_in = 16'hFFFC (delay slot on) -> PC_out = 0x00400014, then 0x00400004; RedirectPending_out = 1 for exactly one cycle.
REQ-034 Same stimulus with the macro off -> PC_out goes 0x00400010 -> 0x00400004, and RedirectPending_out stays 0.
REQ-035 At PC 0x00400020, Jump_in = 1, JumpReg_in = 1, AluResult_in = 0x00401003 -> Misalign_out = 1, and the final target is 0x00401000.
REQ-036 In DELAY, Stall_in = 1 for 2 cycles, then Reset_n_in pulsed low mid-cycle -> PC_out held during the stall, then immediately 0x00400000 with state SEQ.
REQ-037 With RESET_PC = 32'hFFFF_FFF8 -> PC_out sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000; Branch_in and Jump_in both 1 with JumpIndex_in = 26'h1 -> Jump wins, target = 0x00000004 (PC4[31:28] = 0).
